// File: rtl/defog_airlight_ctrl.sv
// Per-frame atmospheric-light (A) estimator: tracks the dark-channel frame maximum and
// steps A toward its clamped value once per frame. Optional stats via DEFOG_AIRLIGHT_STATS_EN.
module defog_airlight_ctrl #(
  parameter logic [7:0] A_DEFAULT    = 8'd255,
  parameter logic [7:0] A_MIN        = 8'd128,
  parameter logic [7:0] A_MAX        = 8'd250,
  parameter int         SMOOTH_SHIFT = 2,
  parameter int         MIN_PIXELS   = 1024,
  parameter int         CNT_W        = 22
) (
  input  logic             pixelclk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       dark_chanel_value,
  input  logic             dark_de,
  input  logic             dark_vsync,
  output logic [7:0]       a,
  output logic             a_update,
  output logic             frame_err
`ifdef DEFOG_AIRLIGHT_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       last_max,
  output logic [CNT_W-1:0] last_pix
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, CALC, UPDATE} state_t;

  state_t                  state_q;
  logic                    vs_q;
  logic                    vs_rise_q;
  logic [7:0]              max_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [8:0]       step_q;
  logic [7:0]              a_q;
  logic                    upd_q;
  logic                    err_q;

  logic                    pix_ok;
  logic [7:0]              max_d;
  logic [CNT_W-1:0]        cnt_d;
  logic [7:0]              tgt_d;
  logic signed [8:0]       diff_d;
  logic signed [8:0]       step_d;
  logic [7:0]              a_d;
  logic                    cnt_ok;

  function automatic logic [7:0] clamp_a(input logic [7:0] v);
    if (v < A_MIN) return A_MIN;
    if (v > A_MAX) return A_MAX;
    return v;
  endfunction

  // Arithmetic shift floors; a residual non-zero error still moves A by one LSB
  // so A always converges onto the target instead of stalling short of it.
  function automatic logic signed [8:0] smooth_step(input logic signed [8:0] d);
    logic signed [8:0] s;
    s = d >>> SMOOTH_SHIFT;
    if (s == 9'sd0 && d != 9'sd0) s = d[8] ? -9'sd1 : 9'sd1;
    return s;
  endfunction

  always_comb begin
    pix_ok = dark_de & ~dark_vsync;
    max_d  = (dark_chanel_value > max_q) ? dark_chanel_value : max_q;
    cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    tgt_d  = clamp_a(max_q);
    diff_d = $signed({1'b0, tgt_d}) - $signed({1'b0, a_q});
    step_d = smooth_step(diff_d);
    a_d    = 8'($signed({1'b0, a_q}) + step_q);
    cnt_ok = (cnt_q >= CNT_W'(MIN_PIXELS));
  end

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      vs_q      <= 1'b0;
      vs_rise_q <= 1'b0;
      max_q     <= '0;
      cnt_q     <= '0;
      step_q    <= '0;
      a_q       <= A_DEFAULT;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      vs_q      <= dark_vsync;
      vs_rise_q <= dark_vsync & ~vs_q;
      upd_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vs_rise_q) begin
            max_q   <= '0;
            cnt_q   <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (pix_ok) begin
            max_q <= max_d;
            cnt_q <= cnt_d;
          end
          if (vs_rise_q) state_q <= CALC;
        end
        CALC: begin
          step_q  <= step_d;
          state_q <= UPDATE;
        end
        UPDATE: begin
          if (cnt_ok) begin
            a_q   <= a_d;
            upd_q <= 1'b1;
            err_q <= 1'b0;
          end else begin
            err_q <= 1'b1;
          end
          max_q   <= '0;
          cnt_q   <= '0;
          state_q <= ACCUM;
        end
        default: state_q <= IDLE;
      endcase
      // Bypass overrides any frame update; the FSM keeps tracking frames meanwhile.
      if (!enable) begin
        a_q   <= A_DEFAULT;
        upd_q <= (a_q != A_DEFAULT);
      end
    end
  end

  assign a         = a_q;
  assign a_update  = upd_q;
  assign frame_err = err_q;

`ifdef DEFOG_AIRLIGHT_STATS_EN
  logic [15:0]      frame_cnt_q;
  logic [7:0]       last_max_q;
  logic [CNT_W-1:0] last_pix_q;

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      last_max_q  <= '0;
      last_pix_q  <= '0;
    end else if (state_q == UPDATE) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
      last_max_q  <= max_q;
      last_pix_q  <= cnt_q;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign last_max  = last_max_q;
  assign last_pix  = last_pix_q;
`endif

endmodule
